// File: rtl/fifo_core.sv
// Single-clock RAM FIFO with an extra wrap bit on each pointer to tell full from empty.
// Read data is registered: dout loads the head word on the edge that accepts rd.
module fifo_core #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    input  logic                  rd,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int PTR_W = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_en;
    logic                  rd_en;

    // Same slot with opposite wrap bits means the writer has lapped the reader.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                   (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
    assign wr_en = wr && !full;
    assign rd_en = rd && !empty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                dout   <= mem[rd_ptr[DEPTH_LOG2-1:0]];
            end
        end
    end

endmodule

// File: rtl/fifo.sv
// Generic FIFO: standard registered-read mode, or first-word fall-through when LOOKAHEAD=1.
// In lookahead mode the core's output register doubles as the head word; only a valid flag is added.
module fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int LOOKAHEAD  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  full,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  empty,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout
);

    logic                  core_rd;
    logic                  core_empty;
    logic [DATA_WIDTH-1:0] core_dout;

    fifo_core #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .wr   (wr),
        .din  (din),
        .full (full),
        .rd   (core_rd),
        .empty(core_empty),
        .dout (core_dout)
    );

    generate
        if (LOOKAHEAD != 0) begin : g_lookahead
            logic head_valid;

            // Refill whenever the head slot is free or being popped this cycle.
            assign core_rd = !core_empty && (!head_valid || rd);
            assign empty   = !head_valid;
            assign dout    = core_dout;

            always_ff @(posedge clk) begin
                if (rst) begin
                    head_valid <= 1'b0;
                end else if (core_rd) begin
                    head_valid <= 1'b1;
                end else if (rd) begin
                    head_valid <= 1'b0;
                end
            end
        end else begin : g_standard
            assign core_rd = rd;
            assign empty   = core_empty;
            assign dout    = core_dout;
        end
    endgenerate

endmodule

// File: tb/tb_fifo.sv
// Directed bench driving one standard-mode and one lookahead-mode fifo side by side.
// Inputs change 1ns after a rising edge; outputs are sampled at that same point.
module tb_fifo;

    localparam int DW    = 8;
    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_s = 1'b0, rd_s = 1'b0, wr_l = 1'b0, rd_l = 1'b0;
    logic [DW-1:0] din_s = '0, din_l = '0;
    logic          full_s, empty_s, full_l, empty_l;
    logic [DW-1:0] dout_s, dout_l;

    int nChecks = 0;
    int nFails  = 0;

    logic [DW-1:0] q_s [$];
    logic [DW-1:0] q_l [$];
    logic [DW-1:0] pat [8] = '{8'h5A, 8'hF6, 8'h09, 8'hC4, 8'h81, 8'hE2, 8'hA0, 8'h7A};

    always #5 clk = ~clk;

    fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2), .LOOKAHEAD(0)) dut_std (
        .clk(clk), .rst(rst), .full(full_s), .wr(wr_s), .din(din_s),
        .empty(empty_s), .rd(rd_s), .dout(dout_s)
    );

    fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2), .LOOKAHEAD(1)) dut_la (
        .clk(clk), .rst(rst), .full(full_l), .wr(wr_l), .din(din_l),
        .empty(empty_l), .rd(rd_l), .dout(dout_l)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive both instances for exactly one clock cycle.
    task automatic applyStimulus(input logic sw, input logic [DW-1:0] sd, input logic sr,
                                 input logic lw, input logic [DW-1:0] ld, input logic lr);
        wr_s = sw; din_s = sd; rd_s = sr;
        wr_l = lw; din_l = ld; rd_l = lr;
        @(posedge clk);
        #1;
        wr_s = 1'b0; rd_s = 1'b0; wr_l = 1'b0; rd_l = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_empty_s"}, 32'(empty_s), 32'd1);
        checkOutput({tag, "_full_s"},  32'(full_s),  32'd0);
        checkOutput({tag, "_dout_s"},  32'(dout_s),  32'd0);
        checkOutput({tag, "_empty_l"}, 32'(empty_l), 32'd1);
        checkOutput({tag, "_full_l"},  32'(full_l),  32'd0);
        checkOutput({tag, "_dout_l"},  32'(dout_l),  32'd0);
    endtask

    initial begin
        int            popped;
        logic          lw;
        logic          lr;
        logic [DW-1:0] ld;
        logic [DW-1:0] exp;
        logic [DW-1:0] held;

        $display("[TB] starting fifo bench");
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkIdle("reset");

        // Standard mode: two writes, two reads.
        applyStimulus(1, 8'h5A, 0, 0, 0, 0);
        checkOutput("std_empty_after_wr", 32'(empty_s), 32'd0);
        applyStimulus(1, 8'hF6, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("std_rd1_dout", 32'(dout_s), 32'h5A);
        checkOutput("std_rd1_empty", 32'(empty_s), 32'd0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("std_rd2_dout", 32'(dout_s), 32'hF6);
        checkOutput("std_rd2_empty", 32'(empty_s), 32'd1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("std_rd_empty_dout", 32'(dout_s), 32'hF6);
        checkOutput("std_rd_empty_empty", 32'(empty_s), 32'd1);

        // Lookahead: back-to-back writes with a random consumer.
        popped = 0;
        for (int cyc = 0; cyc < 100 && popped < 8; cyc++) begin
            lw = (cyc < 8);
            ld = lw ? pat[cyc] : 8'h00;
            lr = 1'($urandom_range(0, 1));
            if (lr && !empty_l) begin
                exp = (q_l.size() > 0) ? q_l.pop_front() : 8'hxx;
                checkOutput("la_order", 32'(dout_l), 32'(exp));
                popped++;
            end
            if (lw) q_l.push_back(ld);
            applyStimulus(0, 0, 0, lw, ld, lr);
        end
        checkOutput("la_popped_count", 32'(popped), 32'd8);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("la_drained_empty", 32'(empty_l), 32'd1);

        // Lookahead: fill DEPTH+1 words, reject one more, drain.
        for (int i = 0; i <= DEPTH; i++) begin
            applyStimulus(0, 0, 0, 1, 8'(8'h10 + i), 0);
            if (i == 0) checkOutput("la_empty_1cyc", 32'(empty_l), 32'd1);
            if (i == 1) checkOutput("la_empty_2cyc", 32'(empty_l), 32'd0);
            if (i == DEPTH - 1) checkOutput("la_not_full_yet", 32'(full_l), 32'd0);
        end
        checkOutput("la_full", 32'(full_l), 32'd1);
        applyStimulus(0, 0, 0, 1, 8'hEE, 0);
        checkOutput("la_full_hold", 32'(full_l), 32'd1);
        for (int i = 0; i <= DEPTH; i++) begin
            checkOutput("la_fill_valid", 32'(empty_l), 32'd0);
            checkOutput("la_fill_order", 32'(dout_l), 32'(8'(8'h10 + i)));
            applyStimulus(0, 0, 0, 0, 0, 1);
            if (i == 0) checkOutput("la_full_release", 32'(full_l), 32'd0);
        end
        checkOutput("la_fill_empty", 32'(empty_l), 32'd1);

        // Standard: half fill, then simultaneous rd/wr across several pointer wraps.
        for (int i = 0; i < DEPTH / 2; i++) begin
            applyStimulus(1, 8'(8'h80 + i), 0, 0, 0, 0);
            q_s.push_back(8'(8'h80 + i));
        end
        for (int i = 0; i < 3 * DEPTH; i++) begin
            ld = 8'(8'h90 + i);
            q_s.push_back(ld);
            exp = q_s.pop_front();
            applyStimulus(1, ld, 1, 0, 0, 0);
            checkOutput("std_wrap_dout", 32'(dout_s), 32'(exp));
            checkOutput("std_wrap_empty", 32'(empty_s), 32'd0);
            checkOutput("std_wrap_full", 32'(full_s), 32'd0);
        end

        // Standard: fill to full, rejected write, full drain.
        held = dout_s;
        for (int i = 0; i < DEPTH / 2; i++) begin
            applyStimulus(1, 8'(8'hC0 + i), 0, 0, 0, 0);
            q_s.push_back(8'(8'hC0 + i));
        end
        checkOutput("std_full", 32'(full_s), 32'd1);
        applyStimulus(1, 8'hEE, 0, 0, 0, 0);
        checkOutput("std_full_hold", 32'(full_s), 32'd1);
        checkOutput("std_full_dout_hold", 32'(dout_s), 32'(held));
        for (int i = 0; i < DEPTH; i++) begin
            exp = (q_s.size() > 0) ? q_s.pop_front() : 8'hxx;
            applyStimulus(0, 0, 1, 0, 0, 0);
            checkOutput("std_drain_dout", 32'(dout_s), 32'(exp));
        end
        checkOutput("std_drain_empty", 32'(empty_s), 32'd1);

        // Mid-stream reset on both instances.
        applyStimulus(1, 8'hA1, 0, 1, 8'hA1, 0);
        applyStimulus(1, 8'hA2, 0, 1, 8'hA2, 0);
        applyStimulus(1, 8'hA3, 1, 1, 8'hA3, 1);
        rst = 1'b1;
        applyStimulus(1, 8'hA4, 1, 1, 8'hA4, 1);
        rst = 1'b0;
        checkIdle("midreset");
        applyStimulus(1, 8'h33, 0, 1, 8'h33, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("post_rst_la_empty", 32'(empty_l), 32'd0);
        checkOutput("post_rst_la_dout", 32'(dout_l), 32'h33);
        applyStimulus(0, 0, 1, 0, 0, 1);
        checkOutput("post_rst_std_dout", 32'(dout_s), 32'h33);
        checkOutput("post_rst_std_empty", 32'(empty_s), 32'd1);
        checkOutput("post_rst_la_empty2", 32'(empty_l), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/fifo.md
# fifo

Synchronous single-clock FIFO buffer for streaming data words between producer and consumer logic in the same clock domain. Two read modes, chosen by parameter: standard, where the read data is registered and appears one cycle after the read strobe, and lookahead (first-word fall-through), where the head word is always on `dout` while `empty` is low and `rd` acknowledges and pops it. Used as the generic buffering primitive across the design.

## Interface
- `DATA_WIDTH`, 32, width of each data word.
- `DEPTH_LOG2`, 4, log2 of core storage depth; the core holds DEPTH = 2^DEPTH_LOG2 words.
- `LOOKAHEAD`, 0, 0 selects standard read mode; 1 selects lookahead (first-word fall-through) mode.

Ports:
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  reset rst, synchronous, active-high; clock clk.
- `full`  output  1  high when a write would be rejected.
- `wr`  input  1  write strobe; accepted when `wr && !full`.
- `din`  input  DATA_WIDTH  write data; sampled on an accepted write.
- `empty`  output  1  high when no word is available to read.
- `rd`  input  1  read strobe; accepted when `rd && !empty`.
- `dout`  output  DATA_WIDTH  read data; timing depends on `LOOKAHEAD`.

## Operation
- Core: DEPTH-entry RAM, write and read pointers of DEPTH_LOG2+1 bits (extra wrap bit). Pointers wrap naturally modulo 2^(DEPTH_LOG2+1).
- Core `empty` when pointers are equal; core `full` when the low bits are equal and the wrap bits differ.
- Write with `full` high is ignored: no state change, and `din` is dropped. Read with `empty` high is ignored.
- Simultaneous accepted read and write update both pointers; the occupancy is unchanged.
- A write while `full` is rejected even if a read is accepted in the same cycle. There is no bypass on the full condition.
- Standard mode (`LOOKAHEAD`=0): on an accepted read, `dout` is loaded with the head word at that edge. Otherwise `dout` holds its last value.
- Lookahead mode (`LOOKAHEAD`=1): a one-entry head register with a valid flag sits after the core.
  - `empty` is the inverse of the valid flag, and `dout` is the head register.
  - When the head register is invalid, or is being popped by an accepted `rd`, and the core is not empty, the core is read and the head register is refilled at the same edge.
  - An accepted `rd` with an empty core clears the valid flag.
  - Total capacity is DEPTH+1 words. `full` is the core full flag.
- Data order is strict FIFO; no word is lost or duplicated.
- Reset at any time, including mid-stream, discards all contents. Reset values: pointers 0, head valid 0, `empty`=1, `full`=0, `dout`=0.

## Timing
- Write-to-`empty` deassertion: 1 cycle in standard mode, 2 cycles in lookahead mode (core write, then head refill).
- Standard read latency: `dout` is valid in the cycle after the edge that accepted `rd`.
- Lookahead: `dout` is valid in any cycle with `empty`=0. The consumer samples `dout` in the same cycle it asserts `rd`; the next word, if any, is on `dout` after that edge.
- `full` asserts on the edge of the write that fills the core. It deasserts on the edge after the first accepted read that removes a word from the core.
- All outputs are registered or derived from registers only; there is no combinational path from `wr`/`rd` to `full`/`empty`.

## Structure
- No shared package needed. Pointer width (DEPTH_LOG2+1) is a local constant.
- One sub-module is natural: `fifo_core`, the standard-mode RAM/pointer FIFO.
  - The top instantiates `fifo_core`.
  - With `LOOKAHEAD`=1, the top adds the head register and valid flag in a generate block.
  - With `LOOKAHEAD`=0, the core outputs are passed through directly.

## Test plan
- Reset then idle, any mode: `empty`=1, `full`=0, `dout`=0. Assert `rst` mid-stream: same values on the next cycle, and old data is never read afterwards.
- Lookahead, random `rd` stream: write 0x5A,0xF6,0x09,0xC4,0x81,0xE2,0xA0,0x7A back-to-back, and toggle `rd` randomly each cycle. Every cycle with `rd && !empty` shows `dout` in that exact order, with no mismatch.
- Lookahead, fill: write DEPTH+1 words with `rd`=0. `full`=1 after the DEPTH-th core write, a further write is ignored, and draining returns exactly the DEPTH+1 words written.
- Standard mode: write 0x5A and 0xF6, then pulse `rd` twice. `dout`=0x5A one cycle after the first pulse and 0xF6 one cycle after the second; `empty`=1 after the second.
- Simultaneous `rd`/`wr` at half occupancy for 3×DEPTH cycles, exercising pointer wrap: occupancy is constant, `full`/`empty` never toggle, and the data order is preserved.
- `rd` on empty and `wr` on full: no pointer change, and `dout` is unchanged in standard mode.
